// File: rtl/s_fifo_pkg.sv
// s_fifo_pkg: default configuration of the single-clock FIFO.
//   DEF_FIFO_WIDTH / DEF_FIFO_DEPTH / DEF_FIFO_BITS / DEF_FIFO_HALF are the
//   default parameter values of s_fifo. DEF_FIFO_DEPTH must be a power of
//   two, DEF_FIFO_BITS = log2(DEF_FIFO_DEPTH), DEF_FIFO_HALF = DEPTH/2.
//   data_t / ptr_t / count_t are the word, pointer and occupancy types for
//   the default configuration.
package s_fifo_pkg;

    localparam int DEF_FIFO_WIDTH = 8;
    localparam int DEF_FIFO_DEPTH = 16;
    localparam int DEF_FIFO_BITS  = 4;
    localparam int DEF_FIFO_HALF  = 8;

    typedef logic [DEF_FIFO_WIDTH-1:0] data_t;
    typedef logic [DEF_FIFO_BITS-1:0]  ptr_t;
    // One bit wider than a pointer so that "full" (DEPTH) is representable.
    typedef logic [DEF_FIFO_BITS:0]    count_t;

endpackage

// File: rtl/s_fifo_ram.sv
// s_fifo_ram: DEPTH x WIDTH register array, one synchronous write port and
// one synchronous (registered) read port.
//   clock    in  rising-edge clock
//   clr_n    in  asynchronous active-low reset; clears only the read register
//   wr_en    in  write enable: mem[wr_addr] <= wr_data
//   wr_addr  in  write address
//   wr_data  in  write data
//   rd_en    in  read enable: rd_data <= mem[rd_addr]
//   rd_addr  in  read address
//   rd_data  out registered read data; holds when rd_en is low
// The storage array itself is never reset.
module s_fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int BITS  = 4
) (
    input  logic             clock,
    input  logic             clr_n,
    input  logic             wr_en,
    input  logic [BITS-1:0]  wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [BITS-1:0]  rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/s_fifo.sv
// s_fifo: single-clock synchronous FIFO with active-low strobes, registered
// read data and occupancy/status outputs.
//   clock     in  rising-edge clock
//   clr_n     in  asynchronous active-low reset
//   data_in   in  write data, sampled when write_n=0
//   read_n    in  active-low read strobe
//   write_n   in  active-low write strobe
//   data_out  out registered read data (valid the cycle after a read accept)
//   full      out counter == FIFO_DEPTH
//   empty     out counter == 0
//   half      out counter >= FIFO_HALF
//   counter   out words stored, 0..FIFO_DEPTH
//   overflow  out (S_FIFO_ERR_FLAGS_EN only) one-cycle pulse: write while full
//   underflow out (S_FIFO_ERR_FLAGS_EN only) one-cycle pulse: read while empty
// Optional feature macro: S_FIFO_ERR_FLAGS_EN.
//
// Handshake: a write is accepted at a rising edge when write_n=0 and full=0;
// a read is accepted when read_n=0 and empty=0. There is no back-pressure
// beyond the flags: a strobe while full/empty is simply dropped.
module s_fifo
    import s_fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int FIFO_BITS  = DEF_FIFO_BITS,
    parameter int FIFO_HALF  = DEF_FIFO_HALF
) (
    input  logic                  clock,
    input  logic                  clr_n,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  read_n,
    input  logic                  write_n,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  half,
`ifdef S_FIFO_ERR_FLAGS_EN
    output logic                  overflow,
    output logic                  underflow,
`endif
    output logic [FIFO_BITS:0]    counter
);

    localparam logic [FIFO_BITS:0] DEPTH_C = FIFO_DEPTH[FIFO_BITS:0];
    localparam logic [FIFO_BITS:0] HALF_C  = FIFO_HALF[FIFO_BITS:0];

    logic [FIFO_BITS-1:0] wr_ptr;
    logic [FIFO_BITS-1:0] rd_ptr;
    logic                 wr_en;
    logic                 rd_en;

    // Acceptance is gated by the flags of the current count, so a read on an
    // empty FIFO never sees the word being written in the same cycle.
    assign wr_en = !write_n && !full;
    assign rd_en = !read_n && !empty;

    assign empty = (counter == '0);
    assign full  = (counter == DEPTH_C);
    assign half  = (counter >= HALF_C);

    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            counter <= '0;
        end else begin
            // Pointers wrap naturally because FIFO_DEPTH is a power of two.
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   counter <= counter + 1'b1;
                2'b01:   counter <= counter - 1'b1;
                default: counter <= counter;
            endcase
        end
    end

`ifdef S_FIFO_ERR_FLAGS_EN
    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= !write_n && full;
            underflow <= !read_n && empty;
        end
    end
`endif

    s_fifo_ram #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .BITS  (FIFO_BITS)
    ) u_ram (
        .clock   (clock),
        .clr_n   (clr_n),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr),
        .rd_data (data_out)
    );

endmodule

// File: tb/tb_s_fifo.sv
// tb_s_fifo: self-checking bench for s_fifo (default 8x16 configuration).
// Reference model: a queue of stored words plus the last word read out.
module tb_s_fifo;

    import s_fifo_pkg::*;

    localparam int DEPTH = 16;
    localparam int HALF  = 8;

    // ---------------- clock / reset ----------------
    logic       clock;
    logic       clr_n;
    logic [7:0] data_in;
    logic       read_n;
    logic       write_n;
    logic [7:0] data_out;
    logic       full;
    logic       empty;
    logic       half;
    logic [4:0] counter;
`ifdef S_FIFO_ERR_FLAGS_EN
    logic       overflow;
    logic       underflow;
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    s_fifo dut (
        .clock    (clock),
        .clr_n    (clr_n),
        .data_in  (data_in),
        .read_n   (read_n),
        .write_n  (write_n),
        .data_out (data_out),
        .full     (full),
        .empty    (empty),
        .half     (half),
`ifdef S_FIFO_ERR_FLAGS_EN
        .overflow  (overflow),
        .underflow (underflow),
`endif
        .counter  (counter)
    );

    // ---------------- scoreboard / model ----------------
    logic [7:0] exp_q[$];
    logic [7:0] exp_dout;
    logic       exp_ovf;
    logic       exp_unf;
    int         total_cnt;
    int         pass_cnt;

    // Expected {counter, empty, half, full} from the model occupancy.
    function automatic logic [7:0] exp_status();
        int n;
        n = exp_q.size();
        exp_status = {n[4:0], n == 0, n >= HALF, n == DEPTH};
    endfunction

    // ---------------- driver ----------------
    // Applies one cycle of strobes, updates the model from the occupancy
    // before the edge, and returns #1 after the edge with strobes idle.
    task automatic step(input bit wr, input bit rd, input logic [7:0] d);
        int n;
        n = exp_q.size();
        write_n = !wr;
        read_n  = !rd;
        data_in = d;
        @(posedge clock);
        exp_ovf = wr && (n == DEPTH);
        exp_unf = rd && (n == 0);
        if (rd && n > 0) exp_dout = exp_q.pop_front();
        if (wr && n < DEPTH) exp_q.push_back(d);
        #1;
        write_n = 1'b1;
        read_n  = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clr_n   = 1'b0;
        write_n = 1'b1;
        read_n  = 1'b1;
        data_in = '0;
        exp_q.delete();
        exp_dout = '0;
        repeat (2) @(posedge clock);
        #1;
        total_cnt++;
        if ({counter, empty, half, full} !== 8'b00000_1_0_0)
            $display("FAIL reset_status: got %b expected %b", {counter, empty, half, full}, 8'b00000_1_0_0);
        else pass_cnt++;
        total_cnt++;
        if (data_out !== 8'h00)
            $display("FAIL reset_data_out: got %h expected 00", data_out);
        else pass_cnt++;
`ifdef S_FIFO_ERR_FLAGS_EN
        total_cnt++;
        if ({overflow, underflow} !== 2'b00)
            $display("FAIL reset_err_flags: got %b expected 00", {overflow, underflow});
        else pass_cnt++;
`endif
        clr_n = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b1, 1'b0, 8'(i));
            total_cnt++;
            if ({counter, empty, half, full} !== exp_status())
                $display("FAIL fill_status[%0d]: got %b expected %b", i, {counter, empty, half, full}, exp_status());
            else pass_cnt++;
        end
    endtask

    task automatic test_overflow();
        step(1'b1, 1'b0, 8'hAA);
        total_cnt++;
        if ({counter, empty, half, full} !== 8'b10000_0_1_1)
            $display("FAIL overflow_status: got %b expected %b", {counter, empty, half, full}, 8'b10000_0_1_1);
        else pass_cnt++;
`ifdef S_FIFO_ERR_FLAGS_EN
        total_cnt++;
        if (overflow !== 1'b1)
            $display("FAIL overflow_pulse: got %b expected 1", overflow);
        else pass_cnt++;
        step(1'b0, 1'b0, 8'h00);
        total_cnt++;
        if (overflow !== 1'b0)
            $display("FAIL overflow_pulse_clear: got %b expected 0", overflow);
        else pass_cnt++;
`endif
    endtask

    task automatic test_drain();
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b0, 1'b1, 8'h00);
            total_cnt++;
            if (data_out !== 8'(i))
                $display("FAIL drain_data[%0d]: got %h expected %h", i, data_out, 8'(i));
            else pass_cnt++;
            total_cnt++;
            if ({counter, empty, half, full} !== exp_status())
                $display("FAIL drain_status[%0d]: got %b expected %b", i, {counter, empty, half, full}, exp_status());
            else pass_cnt++;
        end
    endtask

    task automatic test_underflow();
        step(1'b0, 1'b1, 8'h00);
        total_cnt++;
        if (data_out !== 8'd16)
            $display("FAIL underflow_hold: got %h expected 10", data_out);
        else pass_cnt++;
        total_cnt++;
        if ({counter, empty, half, full} !== 8'b00000_1_0_0)
            $display("FAIL underflow_status: got %b expected %b", {counter, empty, half, full}, 8'b00000_1_0_0);
        else pass_cnt++;
`ifdef S_FIFO_ERR_FLAGS_EN
        total_cnt++;
        if (underflow !== 1'b1)
            $display("FAIL underflow_pulse: got %b expected 1", underflow);
        else pass_cnt++;
`endif
        // Simultaneous read+write on empty: only the write lands.
        step(1'b1, 1'b1, 8'h5C);
        total_cnt++;
        if ({counter, data_out} !== {5'd1, 8'd16})
            $display("FAIL rw_on_empty: got %0d/%h expected 1/10", counter, data_out);
        else pass_cnt++;
        step(1'b0, 1'b1, 8'h00);
        total_cnt++;
        if (data_out !== exp_dout)
            $display("FAIL rw_on_empty_data: got %h expected %h", data_out, exp_dout);
        else pass_cnt++;
    endtask

    task automatic test_concurrent();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'($urandom_range(0, 255)));
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 8'($urandom_range(0, 255)));
            total_cnt++;
            if (counter !== 5'd5 || data_out !== exp_dout)
                $display("FAIL concurrent[%0d]: got %0d/%h expected 5/%h", i, counter, data_out, exp_dout);
            else pass_cnt++;
        end
        // Fill to full, then read+write together: read only.
        while (exp_q.size() < DEPTH) step(1'b1, 1'b0, 8'($urandom_range(0, 255)));
        step(1'b1, 1'b1, 8'hEE);
        total_cnt++;
        if ({counter, empty, half, full} !== exp_status() || data_out !== exp_dout)
            $display("FAIL rw_on_full: got %b/%h expected %b/%h", {counter, empty, half, full}, data_out, exp_status(), exp_dout);
        else pass_cnt++;
    endtask

    task automatic test_random();
        bit wr;
        bit rd;
        for (int i = 0; i < 400; i++) begin
            // Write-heavy first half, read-heavy second half so both ends are hit.
            if (i < 200) begin
                wr = ($urandom_range(0, 3) != 0);
                rd = ($urandom_range(0, 3) == 0);
            end else begin
                wr = ($urandom_range(0, 3) == 0);
                rd = ($urandom_range(0, 3) != 0);
            end
            step(wr, rd, 8'($urandom_range(0, 255)));
            total_cnt++;
            if ({counter, empty, half, full} !== exp_status() || data_out !== exp_dout)
                $display("FAIL random[%0d]: got %b/%h expected %b/%h", i, {counter, empty, half, full}, data_out, exp_status(), exp_dout);
            else pass_cnt++;
`ifdef S_FIFO_ERR_FLAGS_EN
            total_cnt++;
            if ({overflow, underflow} !== {exp_ovf, exp_unf})
                $display("FAIL random_err[%0d]: got %b expected %b", i, {overflow, underflow}, {exp_ovf, exp_unf});
            else pass_cnt++;
`endif
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'(8'h30 + i));
        step(1'b0, 1'b1, 8'h00);
        // Assert reset between edges: outputs must clear without a clock.
        clr_n = 1'b0;
        exp_q.delete();
        exp_dout = '0;
        #2;
        total_cnt++;
        if ({counter, empty, half, full, data_out} !== {8'b00000_1_0_0, 8'h00})
            $display("FAIL reset_mid: got %b/%h expected 00000100/00", {counter, empty, half, full}, data_out);
        else pass_cnt++;
        @(posedge clock);
        #1;
        clr_n = 1'b1;
        step(1'b1, 1'b0, 8'h77);
        step(1'b0, 1'b1, 8'h00);
        total_cnt++;
        if ({counter, data_out} !== {5'd0, 8'h77})
            $display("FAIL after_reset_mid: got %0d/%h expected 0/77", counter, data_out);
        else pass_cnt++;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        total_cnt = 0;
        pass_cnt  = 0;
        exp_ovf   = 1'b0;
        exp_unf   = 1'b0;
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_underflow();
        test_concurrent();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
